// File: rtl/mem_client_if.sv
// Bundle for one memory client: core command/response side plus the
// byte-wide request/ready port toward the memory arbiter.
interface mem_client_if #(
  parameter int M_WIDTH = 32
);
  logic               cmd_valid;
  logic               cmd_ready;
  logic [M_WIDTH-1:0] cmd_addr;
  logic               cmd_we;
  logic [1:0]         cmd_width;
  logic [31:0]        cmd_wdata;
  logic               rsp_valid;
  logic [31:0]        rsp_rdata;
  logic               rsp_err;
  logic               request;
  logic [M_WIDTH-1:0] addr;
  logic               we;
  logic [1:0]         data_width;
  logic [M_WIDTH-1:0] data_out;
  logic               ready;
  logic [M_WIDTH-1:0] mem_rdata;

  modport master (
    input  cmd_valid, cmd_addr, cmd_we, cmd_width, cmd_wdata, ready, mem_rdata,
    output cmd_ready, rsp_valid, rsp_rdata, rsp_err,
           request, addr, we, data_width, data_out
  );

  modport slave (
    output cmd_valid, cmd_addr, cmd_we, cmd_width, cmd_wdata, ready, mem_rdata,
    input  cmd_ready, rsp_valid, rsp_rdata, rsp_err,
           request, addr, we, data_width, data_out
  );
endinterface

// File: rtl/mem_client.sv
// Memory client initiator: splits 8/16/32-bit core accesses into sequential
// byte transactions on the arbiter's four-phase request/ready port.
module mem_client #(
  parameter int         M_WIDTH    = 32,
  parameter logic [1:0] MEM_ACC_8  = 2'b00,
  parameter logic [1:0] MEM_ACC_16 = 2'b01,
  parameter logic [1:0] MEM_ACC_32 = 2'b10
) (
  input logic          clk,
  input logic          rst,
  mem_client_if.master bus
);
  localparam int LANES = M_WIDTH / 8;

  typedef enum logic [1:0] {IDLE, REQ, WAIT_REL, DONE} state_t;

  state_t             state_q, state_d;
  logic               cmd_ready_q, cmd_ready_d;
  logic               request_q, request_d;
  logic [M_WIDTH-1:0] addr_q, addr_d;
  logic               we_q, we_d;
  logic [31:0]        wdata_q, wdata_d;
  logic [7:0]         byte_q, byte_d;
  logic [1:0]         idx_q, idx_d;
  logic [1:0]         last_q, last_d;
  logic               err_q, err_d;
  logic [31:0]        buf_q, buf_d;
  logic               rsp_valid_q, rsp_valid_d;
  logic [31:0]        rsp_rdata_q, rsp_rdata_d;
  logic               rsp_err_q, rsp_err_d;

  logic               cmd_legal;
  logic [1:0]         cmd_last;
  logic [1:0]         idx_next;
  logic [7:0]         lane_bytes [LANES];
  logic [7:0]         lane_byte;

  // The arbiter returns a full memory word; pick the byte lane of the current address.
  generate
    for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
      assign lane_bytes[gi] = bus.mem_rdata[8*gi +: 8];
    end
    if (LANES > 1) begin : g_sel
      assign lane_byte = lane_bytes[addr_q[$clog2(LANES)-1:0]];
    end else begin : g_one
      assign lane_byte = lane_bytes[0];
    end
  endgenerate

  always_comb begin
    cmd_legal = 1'b1;
    cmd_last  = 2'd0;
    case (bus.cmd_width)
      MEM_ACC_8:  cmd_last = 2'd0;
      MEM_ACC_16: cmd_last = 2'd1;
      MEM_ACC_32: cmd_last = 2'd3;
      default:    cmd_legal = 1'b0;
    endcase
  end

  assign idx_next = idx_q + 2'd1;

  always_comb begin
    state_d     = state_q;
    cmd_ready_d = cmd_ready_q;
    request_d   = request_q;
    addr_d      = addr_q;
    we_d        = we_q;
    wdata_d     = wdata_q;
    byte_d      = byte_q;
    idx_d       = idx_q;
    last_d      = last_q;
    err_d       = err_q;
    buf_d       = buf_q;
    rsp_valid_d = 1'b0;
    rsp_rdata_d = rsp_rdata_q;
    rsp_err_d   = rsp_err_q;

    case (state_q)
      IDLE: begin
        cmd_ready_d = 1'b1;
        if (bus.cmd_valid && cmd_ready_q) begin
          cmd_ready_d = 1'b0;
          wdata_d     = bus.cmd_wdata;
          last_d      = cmd_last;
          idx_d       = 2'd0;
          buf_d       = '0;
          if (cmd_legal) begin
            state_d   = REQ;
            request_d = 1'b1;
            addr_d    = bus.cmd_addr;
            we_d      = bus.cmd_we;
            byte_d    = bus.cmd_wdata[7:0];
            err_d     = 1'b0;
          end else begin
            // Illegal width never touches the arbiter; report the error directly.
            state_d = DONE;
            err_d   = 1'b1;
          end
        end
      end

      REQ: begin
        if (bus.ready) begin
          if (!we_q) begin
            buf_d[{idx_q, 3'b000} +: 8] = lane_byte;
          end
          request_d = 1'b0;
          state_d   = WAIT_REL;
        end
      end

      WAIT_REL: begin
        // Four-phase: the next byte may only be requested once ready has dropped.
        if (!bus.ready) begin
          if (idx_q == last_q) begin
            state_d = DONE;
          end else begin
            idx_d     = idx_next;
            addr_d    = addr_q + M_WIDTH'(1);
            byte_d    = wdata_q[{idx_next, 3'b000} +: 8];
            request_d = 1'b1;
            state_d   = REQ;
          end
        end
      end

      DONE: begin
        rsp_valid_d = 1'b1;
        rsp_rdata_d = (we_q || err_q) ? 32'd0 : buf_q;
        rsp_err_d   = err_q;
        // Stay unready during the response cycle so it cannot overlap a new accept.
        cmd_ready_d = 1'b0;
        state_d     = IDLE;
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      cmd_ready_q <= 1'b1;
      request_q   <= 1'b0;
      addr_q      <= '0;
      we_q        <= 1'b0;
      wdata_q     <= '0;
      byte_q      <= '0;
      idx_q       <= '0;
      last_q      <= '0;
      err_q       <= 1'b0;
      buf_q       <= '0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cmd_ready_q <= cmd_ready_d;
      request_q   <= request_d;
      addr_q      <= addr_d;
      we_q        <= we_d;
      wdata_q     <= wdata_d;
      byte_q      <= byte_d;
      idx_q       <= idx_d;
      last_q      <= last_d;
      err_q       <= err_d;
      buf_q       <= buf_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

  assign bus.cmd_ready  = cmd_ready_q;
  assign bus.request    = request_q;
  assign bus.addr       = addr_q;
  assign bus.we         = we_q;
  assign bus.data_width = MEM_ACC_8;
  assign bus.data_out   = M_WIDTH'(byte_q);
  assign bus.rsp_valid  = rsp_valid_q;
  assign bus.rsp_rdata  = rsp_rdata_q;
  assign bus.rsp_err    = rsp_err_q;
endmodule

// File: tb/tb_mem_client.sv
// Self-checking bench for mem_client: directed table, reset corner cases and
// randomized commands against a byte-addressed reference memory.
module tb_mem_client;
  localparam int MW = 32;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        force_ready = 1'b0;
  logic        resp_ready;
  logic [31:0] resp_rdata;

  always #5 clk = ~clk;

  mem_client_if #(.M_WIDTH(MW)) bus_if ();
  assign bus_if.ready     = resp_ready | force_ready;
  assign bus_if.mem_rdata = resp_rdata;

  mem_client #(.M_WIDTH(MW)) dut (.clk(clk), .rst(rst), .bus(bus_if));

  typedef struct {
    logic [31:0] a;
    logic        w;
    logic [7:0]  d;
  } txn_t;

  typedef struct {
    logic [31:0] addr;
    logic        we;
    logic [1:0]  width;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
    logic        exp_err;
  } vec_t;

  txn_t       log_q[$];
  int         n_checks = 0;
  int         n_err = 0;
  int         viol = 0;
  bit [7:0]   dev_mem [bit [31:0]];
  bit [7:0]   ref_mem [bit [31:0]];

  function automatic logic [7:0] byte_init(input logic [31:0] a);
    case (a)
      32'h0000_0000: return 8'hDD;
      32'h0000_0001: return 8'hCC;
      32'h0000_0002: return 8'hBB;
      32'h0000_0003: return 8'hAA;
      32'hFFFF_FFFC: return 8'h01;
      32'hFFFF_FFFD: return 8'h02;
      32'hFFFF_FFFE: return 8'h03;
      32'hFFFF_FFFF: return 8'h5A;
      default:       return a[7:0] ^ a[15:8] ^ a[31:24] ^ 8'hA5;
    endcase
  endfunction

  function automatic logic [7:0] dev_get(input logic [31:0] a);
    return dev_mem.exists(a) ? dev_mem[a] : byte_init(a);
  endfunction

  function automatic logic [7:0] ref_get(input logic [31:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : byte_init(a);
  endfunction

  function automatic int nbytes(input logic [1:0] w);
    case (w)
      2'b00:   return 1;
      2'b01:   return 2;
      2'b10:   return 4;
      default: return 0;
    endcase
  endfunction

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endfunction

  // Arbiter + memory model: random grant delay, releases ready one cycle after request drops.
  initial begin : responder
    int          phase;
    int          dly;
    logic [31:0] la;
    logic [31:0] base;
    logic        lw;
    logic [7:0]  ld;
    resp_ready = 1'b0;
    resp_rdata = 32'h0;
    phase = 0;
    dly = 0;
    forever begin
      @(negedge clk);
      if (rst) begin
        resp_ready = 1'b0;
        phase = 0;
      end else begin
        if (phase == 0 && bus_if.request === 1'b1) begin
          if (bus_if.ready !== 1'b0) viol++;
          if (bus_if.data_out[31:8] !== 24'h0 || bus_if.data_width !== 2'b00) viol++;
          la = bus_if.addr;
          lw = bus_if.we;
          ld = bus_if.data_out[7:0];
          log_q.push_back('{a: la, w: lw, d: ld});
          dly = $urandom_range(0, 3);
          phase = 1;
        end
        if (phase == 1) begin
          if (bus_if.request !== 1'b1 || bus_if.addr !== la || bus_if.we !== lw ||
              bus_if.data_out[7:0] !== ld) viol++;
          if (dly == 0) begin
            base = {la[31:2], 2'b00};
            for (int i = 0; i < 4; i++) resp_rdata[8*i +: 8] = dev_get(base + 32'(i));
            if (lw) dev_mem[la] = ld;
            resp_ready = 1'b1;
            phase = 2;
          end else begin
            dly--;
          end
        end else if (phase == 2) begin
          if (bus_if.request === 1'b0) phase = 3;
        end else if (phase == 3) begin
          if (bus_if.request !== 1'b0) viol++;
          resp_ready = 1'b0;
          resp_rdata = $urandom;
          phase = 0;
        end
      end
    end
  end

  task automatic do_cmd(input logic [31:0] a, input logic w, input logic [1:0] wd,
                        input logic [31:0] d, output logic [31:0] rdata, output logic err,
                        output int lat, output int start, output bit ok);
    int n;
    rdata = 32'h0;
    err = 1'b0;
    lat = 0;
    ok = 1'b0;
    start = log_q.size();
    n = 0;
    while (bus_if.cmd_ready !== 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) begin
      chk("cmd_ready_timeout", 32'd0, 32'd1);
      return;
    end
    start = log_q.size();
    bus_if.cmd_addr  = a;
    bus_if.cmd_we    = w;
    bus_if.cmd_width = wd;
    bus_if.cmd_wdata = d;
    bus_if.cmd_valid = 1'b1;
    @(negedge clk);
    bus_if.cmd_valid = 1'b0;
    bus_if.cmd_addr  = $urandom;
    bus_if.cmd_we    = ~w;
    bus_if.cmd_width = 2'(~wd);
    bus_if.cmd_wdata = $urandom;
    chk("cmd_ready_busy", 32'(bus_if.cmd_ready), 32'd0);
    n = 0;
    while (bus_if.rsp_valid !== 1'b1 && n < 1000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 1000) begin
      chk("rsp_timeout", 32'd0, 32'd1);
      return;
    end
    lat = n + 1;
    chk("cmd_ready_in_rsp", 32'(bus_if.cmd_ready), 32'd0);
    rdata = bus_if.rsp_rdata;
    err = bus_if.rsp_err;
    @(negedge clk);
    chk("rsp_single_pulse", 32'(bus_if.rsp_valid), 32'd0);
    chk("cmd_ready_after", 32'(bus_if.cmd_ready), 32'd1);
    ok = 1'b1;
  endtask

  task automatic run_vec(input vec_t v, input string tag, input bit check_bytes);
    logic [31:0] rdata;
    logic        err;
    int          lat, start, nreq, exp_n;
    bit          ok;
    exp_n = nbytes(v.width);
    do_cmd(v.addr, v.we, v.width, v.wdata, rdata, err, lat, start, ok);
    if (!ok) return;
    $display("%s: addr=0x%08h we=%0d width=%0d wdata=0x%08h -> rdata=0x%08h err=%0d lat=%0d",
             tag, v.addr, v.we, v.width, v.wdata, rdata, err, lat);
    chk($sformatf("%s_rdata", tag), rdata, v.exp_rdata);
    chk($sformatf("%s_err", tag), 32'(err), 32'(v.exp_err));
    chk($sformatf("%s_rdata_hold", tag), bus_if.rsp_rdata, v.exp_rdata);
    nreq = log_q.size() - start;
    chk($sformatf("%s_nreq", tag), 32'(nreq), 32'(exp_n));
    if (v.exp_err) chk($sformatf("%s_err_latency", tag), 32'(lat), 32'd2);
    if (check_bytes) begin
      for (int k = 0; k < nreq && k < exp_n; k++) begin
        chk($sformatf("%s_addr%0d", tag, k), log_q[start+k].a, v.addr + 32'(k));
        chk($sformatf("%s_we%0d", tag, k), 32'(log_q[start+k].w), 32'(v.we));
        if (v.we) chk($sformatf("%s_data%0d", tag, k), 32'(log_q[start+k].d), 32'(v.wdata[8*k +: 8]));
      end
    end
  endtask

  // Reference model: byte-addressed memory, accesses span consecutive addresses with wrap.
  function automatic logic [31:0] ref_read(input logic [31:0] a, input int n);
    logic [31:0] r = 32'h0;
    for (int k = 0; k < n; k++) r[8*k +: 8] = ref_get(a + 32'(k));
    return r;
  endfunction

  function automatic void ref_write(input logic [31:0] a, input logic [31:0] d, input int n);
    for (int k = 0; k < n; k++) ref_mem[a + 32'(k)] = d[8*k +: 8];
  endfunction

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : main
    vec_t        vecs [12];
    vec_t        v;
    logic [31:0] rdata;
    logic        err;
    int          lat, start, pulses, n;
    bit          ok;

    bus_if.cmd_valid = 1'b0;
    bus_if.cmd_addr  = 32'h0;
    bus_if.cmd_we    = 1'b0;
    bus_if.cmd_width = 2'b00;
    bus_if.cmd_wdata = 32'h0;

    vecs[0]  = '{32'h0000_0003, 1'b0, 2'b00, 32'h0,         32'h0000_00AA, 1'b0};
    vecs[1]  = '{32'h0000_0010, 1'b1, 2'b10, 32'h1122_3344, 32'h0,         1'b0};
    vecs[2]  = '{32'h0000_0010, 1'b0, 2'b10, 32'h0,         32'h1122_3344, 1'b0};
    vecs[3]  = '{32'hFFFF_FFFF, 1'b0, 2'b01, 32'h0,         32'h0000_DD5A, 1'b0};
    vecs[4]  = '{32'h0000_0020, 1'b0, 2'b11, 32'h0,         32'h0,         1'b1};
    vecs[5]  = '{32'h0000_0024, 1'b1, 2'b11, 32'hDEAD_BEEF, 32'h0,         1'b1};
    vecs[6]  = '{32'h0000_0011, 1'b0, 2'b01, 32'h0,         32'h0000_2233, 1'b0};
    vecs[7]  = '{32'h0000_0002, 1'b1, 2'b00, 32'hFFFF_FF77, 32'h0,         1'b0};
    vecs[8]  = '{32'h0000_0000, 1'b0, 2'b10, 32'h0,         32'hAA77_CCDD, 1'b0};
    vecs[9]  = '{32'hFFFF_FFFF, 1'b1, 2'b01, 32'hABCD_1234, 32'h0,         1'b0};
    vecs[10] = '{32'hFFFF_FFFE, 1'b0, 2'b10, 32'h0,         32'hCC12_3403, 1'b0};
    vecs[11] = '{32'hFFFF_FFFD, 1'b0, 2'b00, 32'h0,         32'h0000_0002, 1'b0};

    // Reset with ready forced high; ready outside REQ must be ignored afterwards.
    force_ready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_request", 32'(bus_if.request), 32'd0);
    chk("rst_cmd_ready", 32'(bus_if.cmd_ready), 32'd1);
    chk("rst_rsp_valid", 32'(bus_if.rsp_valid), 32'd0);
    chk("rst_rsp_rdata", bus_if.rsp_rdata, 32'd0);
    chk("rst_rsp_err", 32'(bus_if.rsp_err), 32'd0);
    chk("rst_addr", bus_if.addr, 32'd0);
    chk("rst_we", 32'(bus_if.we), 32'd0);
    chk("rst_data_out", bus_if.data_out, 32'd0);
    chk("rst_data_width", 32'(bus_if.data_width), 32'd0);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    chk("idle_ready_ignored_request", 32'(bus_if.request), 32'd0);
    chk("idle_ready_ignored_cmd_ready", 32'(bus_if.cmd_ready), 32'd1);
    chk("idle_ready_ignored_rsp", 32'(bus_if.rsp_valid), 32'd0);
    force_ready = 1'b0;
    repeat (2) @(negedge clk);

    for (int i = 0; i < 12; i++) begin
      run_vec(vecs[i], $sformatf("vec%0d", i), 1'b1);
      if (vecs[i].we && !vecs[i].exp_err) ref_write(vecs[i].addr, vecs[i].wdata, nbytes(vecs[i].width));
    end

    // Reset during the second byte of a 32-bit read.
    while (bus_if.cmd_ready !== 1'b1) @(negedge clk);
    start = log_q.size();
    bus_if.cmd_addr  = 32'h0000_0010;
    bus_if.cmd_we    = 1'b0;
    bus_if.cmd_width = 2'b10;
    bus_if.cmd_valid = 1'b1;
    @(negedge clk);
    bus_if.cmd_valid = 1'b0;
    n = 0;
    while (log_q.size() < start + 2 && n < 200) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("midrst_second_byte_seen", 32'(log_q.size() >= start + 2), 32'd1);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("midrst_request", 32'(bus_if.request), 32'd0);
    chk("midrst_cmd_ready", 32'(bus_if.cmd_ready), 32'd1);
    chk("midrst_rsp_valid", 32'(bus_if.rsp_valid), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    pulses = 0;
    for (int c = 0; c < 15; c++) begin
      @(negedge clk);
      if (bus_if.rsp_valid !== 1'b0) pulses++;
    end
    chk("midrst_no_rsp", 32'(pulses), 32'd0);
    $display("midrst: aborted 32-bit read after %0d byte requests", log_q.size() - start);
    v = '{32'h0000_0013, 1'b0, 2'b00, 32'h0, 32'h0000_0011, 1'b0};
    run_vec(v, "post_rst", 1'b1);

    // Randomized commands against the reference memory.
    for (int i = 0; i < 60; i++) begin
      int r;
      case ($urandom_range(0, 2))
        0:       v.addr = 32'h0000_0100 + 32'($urandom_range(0, 15));
        1:       v.addr = 32'hFFFF_FFF8 + 32'($urandom_range(0, 7));
        default: v.addr = $urandom;
      endcase
      r = $urandom_range(0, 9);
      v.width     = (r == 9) ? 2'b11 : 2'(r % 3);
      v.we        = 1'($urandom_range(0, 1));
      v.wdata     = $urandom;
      v.exp_err   = (v.width == 2'b11);
      v.exp_rdata = (v.we || v.exp_err) ? 32'h0 : ref_read(v.addr, nbytes(v.width));
      run_vec(v, $sformatf("rand%0d", i), 1'b1);
      if (v.we && !v.exp_err) ref_write(v.addr, v.wdata, nbytes(v.width));
    end

    chk("protocol_violations", 32'(viol), 32'd0);
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end
endmodule
